shift_reg_input: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 27 ++
 rtl/half_period_timer.sv | 34 +++
 rtl/shift_reg_input.sv | 133 +++++++++++++
 tb/tb_shift_reg_input.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial shift-register drivers: FSM encodings and
// the chain-length helper (chain length is always a power of two).
package shift_reg_pkg;

  localparam logic [2:0] ST_IDLE_C   = 3'd0;
  localparam logic [2:0] ST_LOAD_C   = 3'd1;
  localparam logic [2:0] ST_SETTLE_C = 3'd2;
  localparam logic [2:0] ST_SAMPLE_C = 3'd3;
  localparam logic [2:0] ST_CLK_HI_C = 3'd4;
  localparam logic [2:0] ST_CLK_LO_C = 3'd5;
  localparam logic [2:0] ST_DONE_C   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_C,
    ST_LOAD   = ST_LOAD_C,
    ST_SETTLE = ST_SETTLE_C,
    ST_SAMPLE = ST_SAMPLE_C,
    ST_CLK_HI = ST_CLK_HI_C,
    ST_CLK_LO = ST_CLK_LO_C,
    ST_DONE   = ST_DONE_C
  } state_t;

  function automatic int chain_len(input int data_width);
    return 1 << data_width;
  endfunction

endpackage

// File: rtl/half_period_timer.sv
// Phase timer: while enabled, o_expired pulses on the last of every
// HALF_PERIOD cycles and the count restarts, so back-to-back timed phases chain.
module half_period_timer #(
  parameter int HALF_PERIOD = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  generate
    if (HALF_PERIOD < 1) begin : g_bad_half_period
      $error("half_period_timer: HALF_PERIOD must be >= 1");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic          w_at_end;

  assign w_at_end  = (r_cnt == CW'(HALF_PERIOD - 1));
  assign o_expired = i_enable && w_at_end;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_enable || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_reg_input.sv
// Reader for a 74HC165-style PISO chain: pulses load, then clocks out N bits
// (first bit into the MSB) and presents the captured word with a valid pulse.
module shift_reg_input
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int HALF_PERIOD = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  input  logic                        i_data_val,
  output logic                        o_load_n,
  output logic                        o_data_clock,
  output logic [(1<<DATA_WIDTH)-1:0]  o_value,
  output logic                        o_valid,
  output logic                        o_busy
);

  localparam int N  = chain_len(DATA_WIDTH);
  localparam int BW = DATA_WIDTH + 1;

  generate
    if (HALF_PERIOD < 1) begin : g_bad_half_period
      $error("shift_reg_input: HALF_PERIOD must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
      $error("shift_reg_input: DATA_WIDTH must be >= 1");
    end
  endgenerate

  state_t          r_state;
  // Only the first N-1 bits need storage; the last bit goes straight to o_value.
  logic [N-2:0]    r_shift;
  logic [BW-1:0]   r_bit_cnt;
  logic [N-1:0]    r_value;
  logic            r_load_n;
  logic            r_data_clock;
  logic            r_valid;
  logic            r_busy;

  logic            w_timer_en;
  logic            w_expired;
  logic [N-1:0]    w_shift_next;
  logic            w_last_bit;

  assign w_timer_en   = (r_state == ST_LOAD)   || (r_state == ST_SETTLE) ||
                        (r_state == ST_CLK_HI) || (r_state == ST_CLK_LO);
  assign w_shift_next = {r_shift, i_data_val};
  assign w_last_bit   = (r_bit_cnt == BW'(N - 1));

  half_period_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  // Chain strobes are registered alongside the state so they never glitch.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_value      <= '0;
      r_load_n     <= 1'b1;
      r_data_clock <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state  <= ST_LOAD;
            r_load_n <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_bit_cnt <= '0;
          if (w_expired) begin
            r_state  <= ST_SETTLE;
            r_load_n <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_expired) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_shift   <= w_shift_next[N-2:0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_last_bit) begin
            r_state <= ST_DONE;
            r_value <= w_shift_next;
            r_valid <= 1'b1;
          end else begin
            r_state      <= ST_CLK_HI;
            r_data_clock <= 1'b1;
          end
        end
        ST_CLK_HI: begin
          if (w_expired) begin
            r_state      <= ST_CLK_LO;
            r_data_clock <= 1'b0;
          end
        end
        ST_CLK_LO: begin
          if (w_expired) r_state <= ST_SAMPLE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_load_n     <= 1'b1;
          r_data_clock <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_load_n     = r_load_n;
  assign o_data_clock = r_data_clock;
  assign o_value      = r_value;
  assign o_valid      = r_valid;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_shift_reg_input.sv
// Directed bench: two readers (default and DATA_WIDTH=3/HALF_PERIOD=1), each
// wired to a behavioural 74HC165 chain model.
module tb_shift_reg_input;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        d_start, d_load_n, d_dclk, d_valid, d_busy;
  logic [15:0] d_value;
  logic [15:0] d_pre   = 16'h0000;
  logic [15:0] d_chain = 16'h0000;

  logic        s_start, s_load_n, s_dclk, s_valid, s_busy;
  logic [7:0]  s_value;
  logic [7:0]  s_pre   = 8'h00;
  logic [7:0]  s_chain = 8'h00;

  shift_reg_input dut_d (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (d_start),
    .i_data_val   (d_chain[15]),
    .o_load_n     (d_load_n),
    .o_data_clock (d_dclk),
    .o_value      (d_value),
    .o_valid      (d_valid),
    .o_busy       (d_busy)
  );

  shift_reg_input #(.DATA_WIDTH(3), .HALF_PERIOD(1)) dut_s (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (s_start),
    .i_data_val   (s_chain[7]),
    .o_load_n     (s_load_n),
    .o_data_clock (s_dclk),
    .o_value      (s_value),
    .o_valid      (s_valid),
    .o_busy       (s_busy)
  );

  // 74HC165 model: parallel load while load_n low, shift toward QH on clock rise.
  always @(posedge d_dclk or negedge d_load_n)
    if (!d_load_n) d_chain <= d_pre;
    else           d_chain <= {d_chain[14:0], 1'b0};

  always @(posedge s_dclk or negedge s_load_n)
    if (!s_load_n) s_chain <= s_pre;
    else           s_chain <= {s_chain[6:0], 1'b0};

  int d_rises = 0, d_loads = 0, d_load_cyc = 0, d_valids = 0, s_rises = 0;
  always @(posedge d_dclk)   d_rises++;
  always @(negedge d_load_n) d_loads++;
  always @(posedge clk)  if (d_load_n === 1'b0) d_load_cyc++;
  always @(negedge clk)  if (d_valid === 1'b1)  d_valids++;
  always @(posedge s_dclk)   s_rises++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Latency counts the i_start-sampling edge as 1; returns at the negedge where o_valid is seen.
  task automatic d_txn(input logic [15:0] pre, output int lat);
    d_pre = pre;
    @(negedge clk); d_start = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); d_start = 1'b0;
    while (d_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  task automatic s_txn(input logic [7:0] pre, output int lat);
    s_pre = pre;
    @(negedge clk); s_start = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); s_start = 1'b0;
    while (s_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, r0, l0, c0, v0;

    rst_n = 1'b0; d_start = 1'b0; s_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load_n", d_load_n, 1);
    chk("rst_dclk",   d_dclk,   0);
    chk("rst_valid",  d_valid,  0);
    chk("rst_busy",   d_busy,   0);
    chk("rst_value",  d_value,  0);
    chk("rst_s_value", s_value, 0);
    rst_n = 1'b1;

    // Default capture
    r0 = d_rises; l0 = d_loads; c0 = d_load_cyc;
    d_txn(16'hA5C3, lat);
    chk("t1_latency", lat, 81);
    chk("t1_value",   d_value, 16'hA5C3);
    chk("t1_rises",   d_rises - r0, 15);
    chk("t1_loads",   d_loads - l0, 1);
    chk("t1_load_cyc", d_load_cyc - c0, 2);
    chk("t1_busy_done", d_busy, 1);
    @(negedge clk);
    chk("t1_valid_pulse", d_valid, 0);
    chk("t1_busy_after", d_busy, 0);

    // Small configuration
    r0 = s_rises;
    s_txn(8'h81, lat);
    chk("t2_latency", lat, 25);
    chk("t2_value",   s_value, 8'h81);
    chk("t2_rises",   s_rises - r0, 7);

    // Start held while busy
    d_pre = 16'h3C5A;
    v0 = d_valids; l0 = d_loads;
    @(negedge clk); d_start = 1'b1;
    lat = 0;
    repeat (40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    d_start = 1'b0;
    while (d_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("t3_latency", lat, 81);
    chk("t3_value",   d_value, 16'h3C5A);
    @(negedge clk);
    chk("t3_busy_after", d_busy, 0);
    repeat (100) @(negedge clk);
    chk("t3_valids", d_valids - v0, 1);
    chk("t3_loads",  d_loads - l0, 1);

    // Back-to-back
    d_txn(16'hFFFF, lat);
    chk("t4a_value", d_value, 16'hFFFF);
    d_txn(16'h0000, lat);
    chk("t4b_latency", lat, 81);
    chk("t4b_value",   d_value, 16'h0000);

    // Reset mid-shift
    d_txn(16'h5A5A, lat);
    chk("t5_pre_value", d_value, 16'h5A5A);
    d_pre = 16'hBEEF;
    @(negedge clk); d_start = 1'b1;
    @(posedge clk);
    @(negedge clk); d_start = 1'b0;
    repeat (29) @(negedge clk);
    chk("t5_busy_mid", d_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy",    d_busy,   0);
    chk("t5_dclk",    d_dclk,   0);
    chk("t5_load_n",  d_load_n, 1);
    chk("t5_value",   d_value,  0);
    rst_n = 1'b1;
    v0 = d_valids;
    repeat (100) @(negedge clk);
    chk("t5_no_valid", d_valids - v0, 0);
    d_txn(16'h1234, lat);
    chk("t5_latency", lat, 81);
    chk("t5_value_new", d_value, 16'h1234);

    // Idle quiet
    @(negedge clk);
    r0 = d_rises; l0 = d_loads; c0 = d_load_cyc; v0 = d_valids;
    repeat (200) @(negedge clk);
    chk("t6_rises",    d_rises - r0, 0);
    chk("t6_loads",    d_loads - l0, 0);
    chk("t6_load_cyc", d_load_cyc - c0, 0);
    chk("t6_valids",   d_valids - v0, 0);
    chk("t6_load_n",   d_load_n, 1);
    chk("t6_dclk",     d_dclk, 0);
    chk("t6_value",    d_value, 16'h1234);
    chk("t6_busy",     d_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
